// File: rtl/knob_scanner.sv
// Periodic Avalon-MM sweep of CH_NUM ADC channels into per-channel level registers.
// Optional hysteresis filter: define KNOB_SCANNER_HYST_EN.
module knob_scanner #(
    parameter int CH_NUM          = 8,
    parameter int DW              = 8,
    parameter int SYS_CLK_FREQ_HZ = 25000000,
    parameter int SCAN_FREQ_HZ    = 100,
    parameter int HYST            = 2,
    parameter int TIMEOUT_CYC     = 4095,
    localparam int AW             = $clog2(CH_NUM)
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 scan_en_i,
    output logic [AW-1:0]        ads_address_o,
    output logic                 ads_read_o,
    input  logic [DW-1:0]        ads_readdata_i,
    input  logic                 ads_readdatavalid_i,
    output logic [CH_NUM*DW-1:0] knob_level_o,
    output logic [CH_NUM-1:0]    knob_changed_o,
    output logic                 scan_done_o,
    output logic                 timeout_o
);

    localparam int PERIOD = SYS_CLK_FREQ_HZ / SCAN_FREQ_HZ;
    localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TOW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

    state_t                   state;
    logic [TW-1:0]            timer;
    logic [TOW-1:0]           tcnt;
    logic                     tick;
    logic                     take;
    logic                     tmo_hit;
    logic                     last_ch;
    logic [CH_NUM-1:0][DW-1:0] lvl;
    logic [CH_NUM-1:0]        upd;

    assign tick    = (timer == TW'(PERIOD - 1));
    assign take    = (state == READ) && ads_readdatavalid_i;
    assign tmo_hit = (state == READ) && !ads_readdatavalid_i && (tcnt == TOW'(TIMEOUT_CYC - 1));
    assign last_ch = (ads_address_o == AW'(CH_NUM - 1));
    assign knob_level_o = lvl;

    always_ff @(posedge clk_i) begin
        if (srst_i)    timer <= '0;
        else if (tick) timer <= '0;
        else           timer <= timer + TW'(1);
    end

    // The address register doubles as the channel index.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state         <= IDLE;
            ads_address_o <= '0;
            ads_read_o    <= 1'b0;
            tcnt          <= '0;
            scan_done_o   <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            scan_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && scan_en_i) begin
                        state         <= READ;
                        ads_address_o <= '0;
                        ads_read_o    <= 1'b1;
                        tcnt          <= '0;
                    end
                end
                READ: begin
                    if (take || tmo_hit) begin
                        state       <= GAP;
                        ads_read_o  <= 1'b0;
                        scan_done_o <= last_ch;
                        if (tmo_hit) timeout_o <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TOW'(1);
                    end
                end
                GAP: begin
                    if (last_ch) begin
                        state <= IDLE;
                    end else begin
                        state         <= READ;
                        ads_address_o <= ads_address_o + AW'(1);
                        ads_read_o    <= 1'b1;
                        tcnt          <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KNOB_SCANNER_HYST_EN
    logic [CH_NUM-1:0] seen;

    // One extra sign bit keeps the difference from wrapping at full scale.
    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic signed [DW:0] diff;
        logic signed [DW:0] mag;
        assign diff   = $signed({1'b0, ads_readdata_i}) - $signed({1'b0, lvl[n]});
        assign mag    = diff[DW] ? -diff : diff;
        assign upd[n] = !seen[n] || (mag > $signed((DW+1)'(HYST)));
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            seen <= '0;
        end else if (take) begin
            for (int n = 0; n < CH_NUM; n++)
                if (ads_address_o == AW'(n)) seen[n] <= 1'b1;
        end
    end
`else
    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        assign upd[n] = 1'b1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lvl            <= '0;
            knob_changed_o <= '0;
        end else begin
            knob_changed_o <= '0;
            if (take) begin
                for (int n = 0; n < CH_NUM; n++) begin
                    if (ads_address_o == AW'(n) && upd[n]) begin
                        lvl[n]            <= ads_readdata_i;
                        knob_changed_o[n] <= (ads_readdata_i != lvl[n]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_knob_scanner.sv
// Randomized bench for knob_scanner: reactive ADC slave with a level model feeding a scoreboard.
module tb_knob_scanner;
    localparam int CH     = 8;
    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int PERIOD = 100;
    localparam int TO     = 20;
    localparam int HY     = 2;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic              scan_en = 1'b0;
    logic [AW-1:0]     addr;
    logic              rd;
    logic [DW-1:0]     rdata = '0;
    logic              rvld = 1'b0;
    logic [CH*DW-1:0]  lvl;
    logic [CH-1:0]     chg;
    logic              done;
    logic              tmo;

    always #5 clk = ~clk;

    knob_scanner #(
        .CH_NUM(CH), .DW(DW), .SYS_CLK_FREQ_HZ(PERIOD * 100), .SCAN_FREQ_HZ(100),
        .HYST(HY), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .srst_i(srst), .scan_en_i(scan_en),
        .ads_address_o(addr), .ads_read_o(rd),
        .ads_readdata_i(rdata), .ads_readdatavalid_i(rvld),
        .knob_level_o(lvl), .knob_changed_o(chg),
        .scan_done_o(done), .timeout_o(tmo)
    );

    typedef struct {
        int               ch;
        int               dur;
        logic [CH*DW-1:0] snap;
        logic [CH-1:0]    chg;
        logic             to;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    int   mlvl[CH];
    bit   mseen[CH];
    bit   mto;
    bit   stall = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CH*DW-1:0] snap_f();
        logic [CH*DW-1:0] s;
        for (int i = 0; i < CH; i++) s[i*DW +: DW] = DW'(mlvl[i]);
        return s;
    endfunction

    // Slave: picks latency and data per read, and predicts the outcome from the level rules.
    initial begin
        int   cnt = 0;
        int   lat = 0;
        int   d = 0;
        int   r, old, dif, c;
        bit   upd;
        exp_t e;
        forever begin
            @(negedge clk);
            if (srst) begin
                cnt = 0;
                rvld = 1'b0;
                for (int i = 0; i < CH; i++) begin mlvl[i] = 0; mseen[i] = 0; end
                mto = 0;
            end else if (rd) begin
                if (cnt == 0) begin
                    r = int'($urandom % 16);
                    if (stall || r == 0) lat = TO + 1;
                    else if (r == 1)     lat = TO;
                    else if (r == 2)     lat = TO - 1;
                    else                 lat = 1 + int'($urandom % 6);
                    c = int'(addr);
                    if ($urandom % 2 == 0) d = int'($urandom % 256);
                    else begin
                        d = mlvl[c] + int'($urandom % 7) - 3;
                        if (d < 0) d = 0;
                        if (d > 255) d = 255;
                    end
                    e.ch  = c;
                    e.dur = (lat > TO) ? TO : lat;
                    e.chg = '0;
                    old   = mlvl[c];
                    if (lat <= TO) begin
                        dif = (d > old) ? d - old : old - d;
`ifdef KNOB_SCANNER_HYST_EN
                        upd = !mseen[c] || (dif > HY);
`else
                        upd = 1'b1;
`endif
                        if (upd) begin
                            mlvl[c] = d;
                            if (d != old) e.chg[c] = 1'b1;
                        end
                        mseen[c] = 1'b1;
                    end else begin
                        mto = 1'b1;
                    end
                    e.to   = mto;
                    e.snap = snap_f();
                    sbq.push_back(e);
                end
                cnt++;
                rvld  = (cnt == lat);
                rdata = rvld ? DW'(d) : DW'($urandom);
            end else begin
                cnt   = 0;
                rvld  = ($urandom % 8 == 0);
                rdata = DW'($urandom);
            end
        end
    end

    // Monitor: sweep timing from the tick grid, scoreboard pop at the end of every read.
    initial begin
        bit            prev = 0, busy = 0, due = 0, clr;
        int            cyc = 0, rcnt = 0, gap = 0, nxt = 0;
        logic [AW-1:0] a0 = '0;
        logic          exp_to = 1'b0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (srst) begin
                prev = 0; busy = 0; due = 0; cyc = 0; rcnt = 0; gap = 0; exp_to = 1'b0;
                sbq.delete();
                continue;
            end
            clr = 0;
            if (!busy) begin
                chk("sweep_start_on_tick", 64'(rd), 64'(due));
                if (rd) begin
                    chk("sweep_start_addr", 64'(addr), 64'd0);
                    busy = 1; a0 = addr; rcnt = 0;
                end
            end else if (rd && !prev) begin
                chk("gap_one_cycle", 64'(gap), 64'd1);
                chk("next_addr", 64'(addr), 64'(nxt));
                a0 = addr; rcnt = 0;
            end
            if (rd) begin
                rcnt++;
                chk("addr_stable", 64'(addr), 64'(a0));
            end
            if (!rd && prev) begin
                chk("sb_depth", 64'(sbq.size()), 64'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("read_addr", 64'(a0), 64'(e.ch));
                    chk("read_cycles", 64'(rcnt), 64'(e.dur));
                    chk("levels", lvl, e.snap);
                    chk("changed", 64'(chg), 64'(e.chg));
                    chk("scan_done", 64'(done), 64'(e.ch == CH - 1));
                    exp_to = e.to;
                    nxt = e.ch + 1;
                    if (e.ch == CH - 1) clr = 1;
                end
                gap = 0;
            end else begin
                chk("changed_quiet", 64'(chg), 64'd0);
                chk("done_quiet", 64'(done), 64'd0);
            end
            if (!rd) gap++;
            chk("timeout_flag", 64'(tmo), 64'(exp_to));
            due = !busy && (cyc % PERIOD == PERIOD - 1) && scan_en;
            if (clr) busy = 0;
            prev = rd;
            cyc++;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read"}, 64'(rd), 64'd0);
        chk({tag, "_addr"}, 64'(addr), 64'd0);
        chk({tag, "_levels"}, lvl, 64'd0);
        chk({tag, "_changed"}, 64'(chg), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_timeout"}, 64'(tmo), 64'd0);
    endtask

    initial begin
        int n, w;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        n = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            if (rd) n++;
        end
        chk("no_read_while_disabled", 64'(n), 64'd0);

        @(posedge clk); #1 scan_en = 1'b1;
        w = 0;
        while (!rd && w < 2 * PERIOD) begin @(negedge clk); w++; end
        chk("first_read_seen", 64'(rd), 64'd1);

        repeat (25) begin
            @(posedge clk); #1 scan_en = ($urandom % 4) != 0;
            repeat (50 + $urandom % 300) @(posedge clk);
        end

        #1 scan_en = 1'b1; stall = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!(rd && addr == AW'(2)) && w < 5000);
        chk("reached_ch2_read", {62'd0, rd, addr == AW'(2)}, 64'd3);
        @(posedge clk); #1;
        chk("in_read_before_reset", 64'(rd), 64'd1);
        srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0; stall = 1'b0; scan_en = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midread_reset");

        repeat (300) @(negedge clk);
        chk("stray_valid_levels", lvl, 64'd0);
        chk("stray_valid_timeout", 64'(tmo), 64'd0);

        @(posedge clk); #1 scan_en = 1'b1;
        repeat (1500) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
